sevenseg_display: RTL and testbench
===================================

# sevenseg_display

Time-multiplexed driver for the board's common-anode seven-segment display, directly downstream of the clock divider. It consumes the divider's `clk_sevenseg` and `clk_blink` square waves as level inputs sampled in the `MegaClk` domain. It scans `NUM_DIGITS` BCD digits with a guard (ghost-suppression) interval between digits, per-digit blinking and per-digit decimal points. All outputs are registered.

## Interface
- `NUM_DIGITS`, 4: digits scanned, legal range 2..8.
- `GUARD_CYCLES`, 2: `MegaClk` cycles with all anodes off after each scan step, legal range 1..255.
- `MegaClk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset; synchronous and active-low.
- `clk_sevenseg`  in  1  scan-rate square wave from the divider; each rising edge advances one digit.
- `clk_blink`  in  1  blink square wave from the divider; low = blinking digits dark.
- `digits`  in  4*NUM_DIGITS  BCD values; digit k at `[4k+3:4k]`; digit 0 is rightmost.
- `blink_mask`  in  NUM_DIGITS  1 = digit k blinks.
- `dp_mask`  in  NUM_DIGITS  1 = decimal point of digit k lit.
- `an`  out  NUM_DIGITS  anode enables, active-low, one-hot-low when driving.
- `seg`  out  7  cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal-point cathode, active-low.

## Operation
- Edge detect: register `scan_q <= clk_sevenseg`.
  - `tick = clk_sevenseg & ~scan_q`.
  - `scan_q` resets to 1, so a high level at reset release does not produce a tick.
- FSM states:
  - IDLE (entered on reset): outputs dark. On tick → BLANK with `idx` = 0.
  - BLANK: `an` all 1, `seg` = 7'h7F, `dp` = 1. Guard counter counts `GUARD_CYCLES` cycles, then → DRIVE.
  - DRIVE: `an[idx]` = 0, all other anodes 1. `seg`/`dp` come from digit `idx`. On tick: `idx` ← `idx`+1, wrapping from `NUM_DIGITS`-1 to 0; guard counter cleared; → BLANK.
- A tick while in BLANK also advances `idx` and restarts the guard count.
- Decode of digit values 0..9: 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10 (hex, active-low).
- Digit values 10..15 decode to 7'h7F (blank).
- Blink: in DRIVE, if `blink_mask[idx]` and `clk_blink`==0, then `seg` = 7'h7F and `dp` = 1. The anode stays asserted so brightness timing is unchanged.
- Decimal point: `dp` = ~`dp_mask[idx]` unless blanked.
- `digits`, `dp_mask` and `blink_mask` are sampled every cycle with no capture. Changes appear on the next cycle.

## Timing
- Reset (`reset_n`=0 at a `MegaClk` edge):
  - Next cycle: `an` = all 1, `seg` = 7'h7F, `dp` = 1, state IDLE, `idx` = 0, guard = 0, `scan_q` = 1.
  - Reset overrides everything, including mid-DRIVE and mid-BLANK.
- Tick detected in cycle T:
  - Cycles T+1 .. T+GUARD_CYCLES: `an` all 1, with `idx` already updated.
  - Cycle T+GUARD_CYCLES+1: new digit driven.
- Input-to-output latency in DRIVE: 1 cycle for `digits`, masks and `clk_blink`.
- One tick is consumed per rising edge of `clk_sevenseg`. A high level held for many cycles yields exactly one tick.
- `idx` width is `$clog2(NUM_DIGITS)`. The wrap compare is explicit, not a power-of-2 overflow.

## Structure
- Package `sevenseg_pkg`:
  - state enum `{IDLE, BLANK, DRIVE}`.
  - `SEG_BLANK` = 7'h7F.
  - 16-entry segment constant table.
- Sub-module `bcd_to_sevenseg`: combinational 4-bit → 7-bit decoder that uses the table. It is instantiated once, on the digit selected by `idx`.
- Top contains the edge detect, FSM, guard counter, `idx` counter and output registers.

## Test plan
- Reset: hold `reset_n`=0 for 10 cycles with `clk_sevenseg` toggling → `an`=4'hF, `seg`=7'h7F, `dp`=1 throughout. After release, still dark until the first `clk_sevenseg` rising edge.
- Scan: `digits`=16'h1234, masks 0, edge every 20 cycles. Required sequence:
  - `an`=1110 with `seg`=19
  - then `an`=1101 with `seg`=30
  - then `an`=1011 with `seg`=24
  - then `an`=0111 with `seg`=79
  - then wrap to `an`=1110.
- Guard: after every tick, `an`==4'hF for exactly `GUARD_CYCLES` (2) cycles. Never two anodes low at once.
- Blink and dp: `blink_mask`=0010, `dp_mask`=0001.
  - Digit 1 with `clk_blink`=0 → `an`=1101, `seg`=7F.
  - Digit 1 with `clk_blink`=1 → `seg`=30.
  - Digit 0 → `dp`=0.
- Invalid BCD: digit 0 = 4'hB → `seg`=7F while `an`=1110.
- Reset mid-operation: pulse `reset_n` low for 1 cycle while driving digit 2 → next cycle dark, IDLE. The next tick drives digit 0.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry k is the pattern for value k; values 10..15 are shown dark.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/bcd_to_sevenseg.sv
// Combinational BCD to active-low seven-segment decoder backed by the
// package table.
module bcd_to_sevenseg
    import sevenseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/sevenseg_display.sv
// Time-multiplexed common-anode display driver: edge-detected scan ticks,
// a dark guard interval after every step, per-digit blink and decimal point.
module sevenseg_display
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    MegaClk,
    input  logic                    reset_n,
    input  logic                    clk_sevenseg,
    input  logic                    clk_blink,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output state_t                  state_dbg
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]       GUARD_LAST = 8'(GUARD_CYCLES - 1);

    logic             scan_q;
    logic             tick;
    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx, idx_inc;
    logic [7:0]       guard, guard_nx;

    logic [3:0]            cur_digit;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] an_nx;
    logic [6:0]            seg_nx;
    logic                  dp_nx;

    assign tick      = clk_sevenseg & ~scan_q;
    assign idx_inc   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        guard_nx = guard;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nx = BLANK;
                    idx_nx   = '0;
                    guard_nx = '0;
                end
            end
            BLANK: begin
                // A tick during the guard interval advances and restarts it.
                if (tick) begin
                    idx_nx   = idx_inc;
                    guard_nx = '0;
                end else if (guard == GUARD_LAST) begin
                    state_nx = DRIVE;
                    guard_nx = '0;
                end else begin
                    guard_nx = guard + 8'd1;
                end
            end
            DRIVE: begin
                if (tick) begin
                    state_nx = BLANK;
                    idx_nx   = idx_inc;
                    guard_nx = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so the anodes go dark
    // on the cycle right after a tick.
    assign cur_digit = digits[{idx_nx, 2'b00} +: 4];

    bcd_to_sevenseg u_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_comb begin
        an_nx  = '1;
        seg_nx = SEG_BLANK;
        dp_nx  = 1'b1;
        if (state_nx == DRIVE) begin
            an_nx[idx_nx] = 1'b0;
            if (!(blink_mask[idx_nx] && !clk_blink)) begin
                seg_nx = dec_seg;
                dp_nx  = ~dp_mask[idx_nx];
            end
        end
    end

    always_ff @(posedge MegaClk) begin
        if (!reset_n) begin
            scan_q <= 1'b1;
            state  <= IDLE;
            idx    <= '0;
            guard  <= '0;
            an     <= '1;
            seg    <= SEG_BLANK;
            dp     <= 1'b1;
        end else begin
            scan_q <= clk_sevenseg;
            state  <= state_nx;
            idx    <= idx_nx;
            guard  <= guard_nx;
            an     <= an_nx;
            seg    <= seg_nx;
            dp     <= dp_nx;
        end
    end

endmodule

// File: tb/tb_sevenseg_display.sv
// Self-checking bench for sevenseg_display against a tick/elapsed-time model
// of the scan sequence.
module tb_sevenseg_display;
    import sevenseg_pkg::*;

    localparam int N     = 4;
    localparam int GUARD = 2;

    logic         MegaClk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clk_sevenseg = 1'b0;
    logic         clk_blink = 1'b1;
    logic [4*N-1:0] digits = 16'h1234;
    logic [N-1:0] blink_mask = '0;
    logic [N-1:0] dp_mask = '0;
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    state_t       state_dbg;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model: ticks seen since reset and cycles elapsed since the latest tick.
    bit         m_started;
    int         m_ticks;
    int         m_since;
    logic       m_prev;
    logic [N-1:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    state_t     exp_state;

    sevenseg_display #(.NUM_DIGITS(N), .GUARD_CYCLES(GUARD)) dut (
        .MegaClk      (MegaClk),
        .reset_n      (reset_n),
        .clk_sevenseg (clk_sevenseg),
        .clk_blink    (clk_blink),
        .digits       (digits),
        .blink_mask   (blink_mask),
        .dp_mask      (dp_mask),
        .an           (an),
        .seg          (seg),
        .dp           (dp),
        .state_dbg    (state_dbg)
    );

    always #5 MegaClk = ~MegaClk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic model_update();
        int k;
        int d;
        if (!reset_n) begin
            m_started = 0;
            m_ticks   = 0;
            m_since   = 0;
            m_prev    = 1'b1;
        end else begin
            if (clk_sevenseg && !m_prev) begin
                m_started = 1;
                m_ticks++;
                m_since = 0;
            end else if (m_since < GUARD) begin
                m_since++;
            end
            m_prev = clk_sevenseg;
        end
        exp_an    = '1;
        exp_seg   = 7'h7F;
        exp_dp    = 1'b1;
        exp_state = !m_started ? IDLE : (m_since >= GUARD ? DRIVE : BLANK);
        if (m_started && m_since >= GUARD) begin
            k = (m_ticks - 1) % N;
            d = int'(digits[4*k +: 4]);
            exp_an[k] = 1'b0;
            if (!(blink_mask[k] && !clk_blink)) begin
                exp_seg = (d < 10) ? seg_ref[d] : 7'h7F;
                exp_dp  = ~dp_mask[k];
            end
        end
    endtask

    task automatic step();
        @(posedge MegaClk);
        model_update();
        @(negedge MegaClk);
    endtask

    task automatic pulse_scan(input int hi, input int lo);
        clk_sevenseg = 1'b1;
        repeat (hi) step();
        clk_sevenseg = 1'b0;
        repeat (lo) step();
    endtask

    task automatic do_reset();
        clk_sevenseg = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clk_sevenseg = i[0];
            step();
            checks++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || state_dbg !== IDLE) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: an=%b seg=%h dp=%b st=%0d, expected an=1111 seg=7f dp=1 st=IDLE",
                         i, an, seg, dp, state_dbg);
            end
        end
        clk_sevenseg = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 6) clk_sevenseg = 1'b0;
            step();
            checks++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || state_dbg !== IDLE) begin
                errors++;
                $display("FAIL reset_release cyc %0d: an=%b seg=%h dp=%b st=%0d, expected dark IDLE",
                         i, an, seg, dp, state_dbg);
            end
        end
        clk_sevenseg = 1'b1;
        for (int i = 0; i < GUARD + 2; i++) begin
            step();
            checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || state_dbg !== exp_state) begin
                errors++;
                $display("FAIL first_tick cyc %0d: an=%b seg=%h dp=%b st=%0d, expected an=%b seg=%h dp=%b st=%0d",
                         i, an, seg, dp, state_dbg, exp_an, exp_seg, exp_dp, exp_state);
            end
        end
        checks++;
        if (an !== 4'b1110 || seg !== 7'h19) begin
            errors++;
            $display("FAIL first_digit: an=%b seg=%h, expected an=1110 seg=19", an, seg);
        end
    endtask

    task automatic test_scan();
        logic [10:0] exp_q[$];
        logic [10:0] got;
        logic [10:0] want;
        bit prev_dark;
        digits = 16'h1234;
        blink_mask = '0;
        dp_mask = '0;
        clk_blink = 1'b1;
        do_reset();
        exp_q.push_back({4'b1110, 7'h19});
        exp_q.push_back({4'b1101, 7'h30});
        exp_q.push_back({4'b1011, 7'h24});
        exp_q.push_back({4'b0111, 7'h79});
        exp_q.push_back({4'b1110, 7'h19});
        prev_dark = 1;
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 20; c++) begin
                clk_sevenseg = (c < 10);
                step();
                checks++;
                if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
                    errors++;
                    $display("FAIL scan p%0d c%0d: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                             p, c, an, seg, dp, exp_an, exp_seg, exp_dp);
                end
                if (an !== 4'hF && prev_dark) begin
                    got = {an, seg};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL scan_order: unexpected digit an=%b seg=%h, expected none", an, seg);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            errors++;
                            $display("FAIL scan_order: an=%b seg=%h, expected an=%b seg=%h",
                                     an, seg, want[10:7], want[6:0]);
                        end
                    end
                end
                prev_dark = (an === 4'hF);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scan_count: %0d digits never shown, expected 0", exp_q.size());
        end
    endtask

    task automatic test_guard();
        int run;
        int hold;
        bit seen_drive;
        do_reset();
        digits = 16'h5678;
        run = 0;
        seen_drive = 0;
        hold = 3;
        for (int c = 0; c < 300; c++) begin
            if (--hold == 0) begin
                clk_sevenseg = ~clk_sevenseg;
                hold = $urandom_range(2, 8);
            end
            step();
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL guard_onehot cyc %0d: an=%b, expected at most one low", c, an);
            end
            if (an === 4'hF) begin
                run++;
            end else begin
                if (seen_drive) begin
                    checks++;
                    if (run != 0 && run != GUARD) begin
                        errors++;
                        $display("FAIL guard_len cyc %0d: dark for %0d cycles, expected %0d", c, run, GUARD);
                    end
                end
                seen_drive = 1;
                run = 0;
            end
        end
    endtask

    task automatic test_blink_dp();
        digits = 16'h1234;
        blink_mask = 4'b0010;
        dp_mask = 4'b0001;
        clk_blink = 1'b0;
        do_reset();
        pulse_scan(5, 5);
        checks++;
        if (an !== 4'b1110 || seg !== 7'h19 || dp !== 1'b0) begin
            errors++;
            $display("FAIL dp_digit0: an=%b seg=%h dp=%b, expected an=1110 seg=19 dp=0", an, seg, dp);
        end
        pulse_scan(5, 5);
        checks++;
        if (an !== 4'b1101 || seg !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL blink_dark: an=%b seg=%h dp=%b, expected an=1101 seg=7f dp=1", an, seg, dp);
        end
        clk_blink = 1'b1;
        step();
        checks++;
        if (an !== 4'b1101 || seg !== 7'h30 || dp !== 1'b1) begin
            errors++;
            $display("FAIL blink_lit: an=%b seg=%h dp=%b, expected an=1101 seg=30 dp=1", an, seg, dp);
        end
        blink_mask = '0;
        dp_mask = '0;
    endtask

    task automatic test_invalid();
        logic [3:0] bad [3] = '{4'hB, 4'hC, 4'hF};
        digits = 16'h123B;
        do_reset();
        pulse_scan(5, 5);
        for (int i = 0; i < 3; i++) begin
            digits[3:0] = bad[i];
            step();
            checks++;
            if (an !== 4'b1110 || seg !== 7'h7F || dp !== 1'b1) begin
                errors++;
                $display("FAIL invalid_bcd %h: an=%b seg=%h dp=%b, expected an=1110 seg=7f dp=1",
                         bad[i], an, seg, dp);
            end
        end
        digits[3:0] = 4'h9;
        step();
        checks++;
        if (seg !== 7'h10) begin
            errors++;
            $display("FAIL bcd_latency: seg=%h, expected 10", seg);
        end
    endtask

    task automatic test_reset_mid();
        digits = 16'h1234;
        do_reset();
        pulse_scan(5, 5);
        pulse_scan(5, 5);
        pulse_scan(5, 5);
        checks++;
        if (an !== 4'b1011 || seg !== 7'h24) begin
            errors++;
            $display("FAIL mid_digit2: an=%b seg=%h, expected an=1011 seg=24", an, seg);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL mid_reset: an=%b seg=%h dp=%b st=%0d, expected dark IDLE", an, seg, dp, state_dbg);
        end
        step();
        pulse_scan(5, 5);
        checks++;
        if (an !== 4'b1110 || seg !== 7'h19) begin
            errors++;
            $display("FAIL mid_restart: an=%b seg=%h, expected an=1110 seg=19", an, seg);
        end
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        hold = 1;
        for (int c = 0; c < 2000; c++) begin
            if (--hold == 0) begin
                clk_sevenseg = ~clk_sevenseg;
                hold = $urandom_range(1, 15);
            end
            if ($urandom_range(0, 7) == 0) clk_blink = ~clk_blink;
            if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 19) == 0) dp_mask = 4'($urandom);
            reset_n = ($urandom_range(0, 299) != 0);
            step();
            checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || state_dbg !== exp_state) begin
                errors++;
                $display("FAIL random cyc %0d: an=%b seg=%h dp=%b st=%0d, expected an=%b seg=%h dp=%b st=%0d",
                         c, an, seg, dp, state_dbg, exp_an, exp_seg, exp_dp, exp_state);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_guard();
        test_blink_dp();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
